fft_stage_sequencer: RTL and testbench

- Top-level scheduler for an in-place radix-2 DIF FFT built around one shared butterfly and a ping-pong pair of dual-port RAM banks.
- On start, runs all log2(N) stages, issuing one butterfly per cycle. For each butterfly it issues two read addresses, a twiddle ROM index, and the matching write-back addresses delayed by the butterfly latency.
- Selects which bank each stage reads and writes, and reports the bank holding the final result.

---
 rtl/fft_stage_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly scheduler for an in-place radix-2 DIF FFT with a shared
// butterfly and ping-pong RAM banks; write-backs trail reads by BF_LAT cycles.
module fft_stage_sequencer #(
   parameter int N      = 16,
   parameter int SIZE   = 4,
   parameter int BF_LAT = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            clr,
   output logic            busy,
   output logic            done,
   output logic [SIZE-1:0] stage,
   output logic            rd_en,
   output logic [SIZE-1:0] rd_adr_a,
   output logic [SIZE-1:0] rd_adr_b,
   output logic [SIZE-2:0] tw_adr,
   output logic            rd_bank,
   output logic            wr_en,
   output logic [SIZE-1:0] wr_adr_a,
   output logic [SIZE-1:0] wr_adr_b,
   output logic            wr_bank,
   output logic            result_bank,
   output logic [2:0]      dbg_state
);

   // Handshake: start is a single-cycle request honoured only in IDLE; clr
   // overrides everything; rd_en/wr_en qualify their address buses in-cycle.

   typedef enum logic [2:0] {IDLE, RUN, DRAIN, NEXT, DONE} state_t;

   typedef struct packed {
      logic [SIZE-1:0] a;
      logic [SIZE-1:0] b;
      logic [SIZE-2:0] tw;
   } bfly_t;

   localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
   localparam logic [SIZE-1:0] LAST_STAGE = SIZE'(SIZE - 1);
   localparam logic [SIZE-1:0] STAGE_ONE  = SIZE'(1);
   localparam logic [SIZE-2:0] J_LAST     = (SIZE-1)'(N / 2 - 1);
   localparam logic [SIZE-2:0] J_ONE      = (SIZE-1)'(1);
   localparam logic [DW-1:0]   D_LAST     = DW'(BF_LAT - 1);
   localparam logic [DW-1:0]   D_ONE      = DW'(1);

   state_t          state_q, state_d;
   logic [SIZE-1:0] stage_q, stage_d;
   logic [SIZE-2:0] j_q, j_d;
   logic [DW-1:0]   dcnt_q, dcnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            rd_en_q, rd_en_d;
   logic            wr_bank_q, wr_bank_d;
   logic [SIZE-1:0] rd_a_q, rd_a_d;
   logic [SIZE-1:0] rd_b_q, rd_b_d;
   logic [SIZE-2:0] tw_q, tw_d;
   bfly_t           bf_calc;

   logic [BF_LAT-1:0] en_dl_q;
   logic [SIZE-1:0]   a_dl_q [BF_LAT];
   logic [SIZE-1:0]   b_dl_q [BF_LAT];

   function automatic bfly_t bfly_adr(input logic [SIZE-1:0] s, input logic [SIZE-2:0] j);
      bfly_t       r;
      int unsigned span, pos, grp;
      span = N >> (int'(s) + 1);
      pos  = int'(j) & (span - 1);
      grp  = int'(j) >> (SIZE - 1 - int'(s));
      r.a  = SIZE'(grp * 2 * span + pos);
      r.b  = SIZE'(grp * 2 * span + pos + span);
      r.tw = (SIZE-1)'(pos << s);
      return r;
   endfunction

   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      j_d       = j_q;
      dcnt_d    = dcnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rd_en_d   = 1'b0;
      wr_bank_d = wr_bank_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               stage_d   = '0;
               j_d       = '0;
               busy_d    = 1'b1;
               wr_bank_d = 1'b1;
               rd_en_d   = 1'b1;
            end
         end
         RUN: begin
            if (j_q == J_LAST) begin
               state_d = DRAIN;
               dcnt_d  = '0;
            end else begin
               j_d     = j_q + J_ONE;
               rd_en_d = 1'b1;
            end
         end
         DRAIN: begin
            if (dcnt_q == D_LAST) begin
               if (stage_q < LAST_STAGE) begin
                  state_d   = NEXT;
                  stage_d   = stage_q + STAGE_ONE;
                  // next stage writes the bank this stage read
                  wr_bank_d = stage_q[0];
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end else begin
               dcnt_d = dcnt_q + D_ONE;
            end
         end
         NEXT: begin
            state_d = RUN;
            j_d     = '0;
            rd_en_d = 1'b1;
         end
         DONE: begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            stage_d   = '0;
            wr_bank_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      if (clr) begin
         state_d   = IDLE;
         stage_d   = '0;
         j_d       = '0;
         dcnt_d    = '0;
         busy_d    = 1'b0;
         done_d    = 1'b0;
         rd_en_d   = 1'b0;
         wr_bank_d = 1'b0;
      end
   end

   assign bf_calc = bfly_adr(stage_d, j_d);
   assign rd_a_d  = rd_en_d ? bf_calc.a  : '0;
   assign rd_b_d  = rd_en_d ? bf_calc.b  : '0;
   assign tw_d    = rd_en_d ? bf_calc.tw : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         stage_q   <= '0;
         j_q       <= '0;
         dcnt_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         wr_bank_q <= 1'b0;
         rd_a_q    <= '0;
         rd_b_q    <= '0;
         tw_q      <= '0;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         j_q       <= j_d;
         dcnt_q    <= dcnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rd_en_q   <= rd_en_d;
         wr_bank_q <= wr_bank_d;
         rd_a_q    <= rd_a_d;
         rd_b_q    <= rd_b_d;
         tw_q      <= tw_d;
      end
   end

   // Write-back delay line mirrors the butterfly pipeline depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_dl_q <= '0;
         for (int i = 0; i < BF_LAT; i++) begin
            a_dl_q[i] <= '0;
            b_dl_q[i] <= '0;
         end
      end else if (clr) begin
         en_dl_q <= '0;
         for (int i = 0; i < BF_LAT; i++) begin
            a_dl_q[i] <= '0;
            b_dl_q[i] <= '0;
         end
      end else begin
         en_dl_q[0] <= rd_en_q;
         a_dl_q[0]  <= rd_a_q;
         b_dl_q[0]  <= rd_b_q;
         for (int i = 1; i < BF_LAT; i++) begin
            en_dl_q[i] <= en_dl_q[i-1];
            a_dl_q[i]  <= a_dl_q[i-1];
            b_dl_q[i]  <= b_dl_q[i-1];
         end
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign stage       = stage_q;
   assign rd_en       = rd_en_q;
   assign rd_adr_a    = rd_a_q;
   assign rd_adr_b    = rd_b_q;
   assign tw_adr      = tw_q;
   assign rd_bank     = stage_q[0];
   assign wr_en       = en_dl_q[BF_LAT-1];
   assign wr_adr_a    = a_dl_q[BF_LAT-1];
   assign wr_adr_b    = b_dl_q[BF_LAT-1];
   assign wr_bank     = wr_bank_q;
   assign result_bank = ~LAST_STAGE[0];
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (N=16, BF_LAT=3): cycle-by-cycle
// schedule model, hand-computed address vectors, clr and async reset cases.
module tb_fft_stage_sequencer;
   localparam int N = 16, SIZE = 4, BF_LAT = 3;

   logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, clr = 1'b0;
   logic            busy, done, rd_en, rd_bank, wr_en, wr_bank, result_bank;
   logic [SIZE-1:0] stage, rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b;
   logic [SIZE-2:0] tw_adr;
   logic [2:0]      dbg_state;

   int n_checks = 0, n_fail = 0;
   int wr_cnt, dn_cnt;
   int dir_t  [8] = '{0, 1, 7, 12, 15, 16, 36, 43};
   int dir_a  [8] = '{0, 1, 7, 0, 3, 8, 0, 14};
   int dir_b  [8] = '{8, 9, 15, 4, 7, 12, 1, 15};
   int dir_tw [8] = '{0, 1, 7, 0, 6, 0, 0, 0};

   fft_stage_sequencer #(.N(N), .SIZE(SIZE), .BF_LAT(BF_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
      .busy(busy), .done(done), .stage(stage), .rd_en(rd_en),
      .rd_adr_a(rd_adr_a), .rd_adr_b(rd_adr_b), .tw_adr(tw_adr),
      .rd_bank(rd_bank), .wr_en(wr_en), .wr_adr_a(wr_adr_a),
      .wr_adr_b(wr_adr_b), .wr_bank(wr_bank), .result_bank(result_bank),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model_adr(input int s, input int j, output int a, output int b, output int tw);
      int half;
      half = N >> (s + 1);
      a    = (j / half) * 2 * half + (j % half);
      b    = a + half;
      tw   = ((j % half) * (1 << s)) % (N / 2);
   endfunction

   // t counts cycles from the first rd_en cycle; one stage = 12 cycles
   task automatic check_cycle(input int t);
      int s, w, stg, a, b, tw, wa, wb, wtw;
      bit rd, wr, dn, bsy;
      s = t / 12;
      w = t % 12;
      if (t >= 48) begin
         rd = 0; stg = 0; bsy = 0; dn = 0;
      end else begin
         rd  = (w < 8);
         stg = (w == 11 && s < 3) ? s + 1 : s;
         dn  = (t == 47);
         bsy = 1;
      end
      wr = (t >= 3) && (t - 3 < 48) && (((t - 3) % 12) < 8);
      check($sformatf("rd_en t%0d", t), rd_en, rd);
      check($sformatf("stage t%0d", t), stage, stg);
      check($sformatf("busy t%0d", t), busy, bsy);
      check($sformatf("done t%0d", t), done, dn);
      check($sformatf("rd_bank t%0d", t), rd_bank, stg % 2);
      check($sformatf("wr_bank t%0d", t), wr_bank, bsy ? 1 - (stg % 2) : 0);
      check($sformatf("wr_en t%0d", t), wr_en, wr);
      if (rd) begin
         model_adr(s, w, a, b, tw);
         check($sformatf("rd_adr_a t%0d", t), rd_adr_a, a);
         check($sformatf("rd_adr_b t%0d", t), rd_adr_b, b);
         check($sformatf("tw_adr t%0d", t), tw_adr, tw);
      end
      if (wr) begin
         model_adr((t - 3) / 12, (t - 3) % 12, wa, wb, wtw);
         check($sformatf("wr_adr_a t%0d", t), wr_adr_a, wa);
         check($sformatf("wr_adr_b t%0d", t), wr_adr_b, wb);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      // reset
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset rd_en", rd_en, 0);
      check("reset wr_en", wr_en, 0);
      check("reset stage", stage, 0);
      check("reset wr_bank", wr_bank, 0);
      check("reset done", done, 0);
      check("reset state", dbg_state, 0);
      check("result_bank", result_bank, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // full transform, with an ignored start at stage 1 j=3
      wr_cnt = 0;
      dn_cnt = 0;
      pulse_start();
      for (int t = 0; t <= 48; t++) begin
         check_cycle(t);
         for (int k = 0; k < 8; k++) begin
            if (dir_t[k] == t) begin
               check($sformatf("dir_a t%0d", t), rd_adr_a, dir_a[k]);
               check($sformatf("dir_b t%0d", t), rd_adr_b, dir_b[k]);
               check($sformatf("dir_tw t%0d", t), tw_adr, dir_tw[k]);
            end
         end
         if (wr_en) wr_cnt++;
         if (done) dn_cnt++;
         start = (t == 15);
         @(negedge clk);
      end
      start = 1'b0;
      check("wr pulses", wr_cnt, 32);
      check("done pulses", dn_cnt, 1);

      // clr and start together in IDLE
      start = 1'b1;
      clr   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      clr   = 1'b0;
      check("clr+start busy", busy, 0);
      check("clr+start rd_en", rd_en, 0);
      check("clr+start state", dbg_state, 0);
      @(negedge clk);
      check("clr+start idle", rd_en, 0);

      // clr during stage 2 DRAIN
      pulse_start();
      for (int t = 0; t <= 33; t++) begin
         check_cycle(t);
         if (t < 33) @(negedge clk);
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr wr_en", wr_en, 0);
      check("clr busy", busy, 0);
      check("clr stage", stage, 0);
      check("clr rd_en", rd_en, 0);
      check("clr done", done, 0);
      check("clr state", dbg_state, 0);
      wr_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (wr_en) wr_cnt++;
      end
      check("leftover writes", wr_cnt, 0);

      // clean restart after clr
      pulse_start();
      for (int t = 0; t <= 11; t++) begin
         check_cycle(t);
         @(negedge clk);
      end

      // async reset mid-run
      pulse_start();
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst rd_en", rd_en, 0);
      check("arst busy", busy, 0);
      check("arst wr_en", wr_en, 0);
      check("arst stage", stage, 0);
      check("arst state", dbg_state, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post arst idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
